// File: rtl/chip_slot_arbiter.sv
// Chip-RAM bus slot arbiter: counts two-CLK colour-clock slots along a line and registers one owner per slot.
// Optional feature: define ARB_NTSC_LONGLINE_EN for alternating long/short lines driven by LOL.
module chip_slot_arbiter #(
    parameter int LINE_SLOTS = 227,
    parameter int STARVE_MAX = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DMAEN,
    input  logic       DSKEN,
    input  logic       SPREN,
    input  logic       COPEN,
    input  logic       BLTEN,
    input  logic [3:0] AUDEN,
    input  logic       BPL_REQ,
    input  logic       COP_REQ,
    input  logic       BLT_REQ,
    input  logic       BLTPRI,
    input  logic       CPU_REQ,
    output logic [3:0] GNT_ID,
    output logic       SLOT_PH,
    output logic [7:0] HPOS,
    output logic       HSTROBE,
    output logic       LOL,
    output logic       _DBR,
    output logic       CPU_ACK
);

    typedef enum logic [3:0] {
        OWN_IDLE = 4'd0,
        OWN_REF  = 4'd1,
        OWN_DSK  = 4'd2,
        OWN_AUD  = 4'd3,
        OWN_SPR  = 4'd4,
        OWN_BPL  = 4'd5,
        OWN_COP  = 4'd6,
        OWN_BLT  = 4'd7,
        OWN_CPU  = 4'd8
    } owner_e;

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic          ph;
    logic [7:0]    hpos;
    owner_e        gnt;
    logic [CW-1:0] starve_cnt;
    logic          cpu_done;

    logic [7:0]    last_slot;
    logic          wrap_point;
    logic [7:0]    next_hpos;
    logic [1:0]    aud_sel;
    owner_e        fixed_owner;
    logic          fixed_taken;
    owner_e        next_gnt;
    logic [CW-1:0] starve_next;
    logic          cpu_ack;
    logic          cpu_eff;
    logic          relief;

`ifdef ARB_NTSC_LONGLINE_EN
    logic lol;

    assign last_slot = lol ? 8'(LINE_SLOTS) : 8'(LINE_SLOTS - 1);
    assign LOL       = lol;
`else
    assign last_slot = 8'(LINE_SLOTS - 1);
    assign LOL       = 1'b0;
`endif

    assign wrap_point = (hpos == last_slot);
    assign next_hpos  = wrap_point ? 8'd0 : hpos + 8'd1;
    assign aud_sel    = 2'((next_hpos - 8'h0F) >> 1);

    // The ACK cycle itself must not feed the next decision, or a held request would be granted twice.
    assign cpu_ack = ph && (gnt == OWN_CPU);
    assign cpu_eff = CPU_REQ && !cpu_done && !cpu_ack;
    assign relief  = !BLTPRI && (starve_cnt == CNT_MAX);

    always_comb begin
        fixed_owner = OWN_IDLE;
        fixed_taken = 1'b0;
        if (next_hpos[0]) begin
            if (next_hpos <= 8'h07) begin
                fixed_owner = OWN_REF;
                fixed_taken = 1'b1;
            end else if (next_hpos <= 8'h0D) begin
                fixed_owner = OWN_DSK;
                fixed_taken = DMAEN && DSKEN;
            end else if (next_hpos <= 8'h15) begin
                fixed_owner = OWN_AUD;
                fixed_taken = DMAEN && AUDEN[aud_sel];
            end else if (next_hpos <= 8'h35) begin
                fixed_owner = OWN_SPR;
                fixed_taken = DMAEN && SPREN;
            end
        end
    end

    // Free-slot arbitration; a starved CPU jumps ahead of the blitter only.
    always_comb begin
        next_gnt = OWN_IDLE;
        if (fixed_taken) begin
            next_gnt = fixed_owner;
        end else if (DMAEN && BPL_REQ) begin
            next_gnt = OWN_BPL;
        end else if (DMAEN && COPEN && COP_REQ && !next_hpos[0]) begin
            next_gnt = OWN_COP;
        end else if (cpu_eff && relief) begin
            next_gnt = OWN_CPU;
        end else if (DMAEN && BLTEN && BLT_REQ) begin
            next_gnt = OWN_BLT;
        end else if (cpu_eff) begin
            next_gnt = OWN_CPU;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (!CPU_REQ) begin
            starve_next = '0;
        end else if (!fixed_taken) begin
            if (next_gnt == OWN_CPU) begin
                starve_next = '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_next = starve_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ph         <= 1'b0;
            hpos       <= 8'd0;
            gnt        <= OWN_IDLE;
            starve_cnt <= '0;
            cpu_done   <= 1'b0;
`ifdef ARB_NTSC_LONGLINE_EN
            lol        <= 1'b0;
`endif
        end else begin
            ph <= ~ph;
            if (!CPU_REQ) begin
                cpu_done <= 1'b0;
            end else if (cpu_ack) begin
                cpu_done <= 1'b1;
            end
            if (ph) begin
                hpos       <= next_hpos;
                gnt        <= next_gnt;
                starve_cnt <= starve_next;
`ifdef ARB_NTSC_LONGLINE_EN
                if (wrap_point) begin
                    lol <= ~lol;
                end
`endif
            end
        end
    end

    assign GNT_ID  = gnt;
    assign SLOT_PH = ph;
    assign HPOS    = hpos;
    assign HSTROBE = ph && wrap_point;
    assign CPU_ACK = cpu_ack;
    assign _DBR    = !(CPU_REQ && (gnt != OWN_CPU));

endmodule

// File: tb/tb_chip_slot_arbiter.sv
// Directed bench for chip_slot_arbiter: per-cycle slot position, grant, ACK, _DBR and strobe checks.
module tb_chip_slot_arbiter;

    localparam int LINE = 227;

    logic       CLK = 1'b0;
    logic       RST;
    logic       dmaen, dsken, spren, copen, blten;
    logic [3:0] auden;
    logic       bpl_req, cop_req, blt_req, bltpri, cpu_req;
    logic [3:0] gnt_id;
    logic       slot_ph;
    logic [7:0] hpos;
    logic       hstrobe, lol, dbr_n, cpu_ack;

    int total = 0;
    int bad   = 0;
    int hp_m  = 0;
    int ph_m  = 0;
    int lol_m = 0;
    bit ack_last = 1'b0;

    chip_slot_arbiter #(.LINE_SLOTS(LINE), .STARVE_MAX(3)) dut (
        .CLK(CLK), .RST(RST), .DMAEN(dmaen), .DSKEN(dsken), .SPREN(spren),
        .COPEN(copen), .BLTEN(blten), .AUDEN(auden), .BPL_REQ(bpl_req),
        .COP_REQ(cop_req), .BLT_REQ(blt_req), .BLTPRI(bltpri), .CPU_REQ(cpu_req),
        .GNT_ID(gnt_id), .SLOT_PH(slot_ph), .HPOS(hpos), .HSTROBE(hstrobe),
        .LOL(lol), ._DBR(dbr_n), .CPU_ACK(cpu_ack)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (model hpos %0d ph %0d)", tag, observed, expected, hp_m, ph_m);
        end
    endtask

    function automatic int last_m();
`ifdef ARB_NTSC_LONGLINE_EN
        return (lol_m != 0) ? LINE : LINE - 1;
`else
        return LINE - 1;
`endif
    endfunction

    // Advance one CLK; the position model follows the DUT and sampling happens on the falling edge.
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            hp_m = 0; ph_m = 0; lol_m = 0;
        end else begin
            if (ph_m == 1) begin
                if (hp_m == last_m()) begin
                    hp_m = 0;
`ifdef ARB_NTSC_LONGLINE_EN
                    lol_m = 1 - lol_m;
`endif
                end else begin
                    hp_m++;
                end
            end
            ph_m = 1 - ph_m;
        end
        @(negedge CLK);
    endtask

    // Hand-derived owner per slot for each directed scenario, starting from a fresh reset.
    function automatic int exp_gnt(int id, int hp);
        bit is_ref;
        is_ref = (hp % 2 == 1) && (hp <= 7);
        if (hp == 0) return 0;
        if (is_ref) return 1;
        case (id)
            2: return (hp % 2 == 0) ? 8 : 0;
            3: return (hp < 8) ? 7 : (((hp - 8) % 4 == 0) ? 8 : 7);
            4: return 7;
            5: return (hp % 2 == 0) ? 6 : 7;
            6: begin
                if (hp == 9 || hp == 11 || hp == 13) return 2;
                if (hp == 15 || hp == 19) return 3;
                if (hp % 2 == 1 && hp >= 23 && hp <= 53) return 4;
                return 5;
            end
            7: return (hp == 2) ? 8 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic applyStimulus(input int id);
        dmaen = 1'b0; dsken = 1'b0; spren = 1'b0; copen = 1'b0; blten = 1'b0;
        auden = 4'b0000; bpl_req = 1'b0; cop_req = 1'b0; blt_req = 1'b0;
        bltpri = 1'b0; cpu_req = 1'b0;
        case (id)
            2: begin bpl_req = 1'b1; blt_req = 1'b1; blten = 1'b1; cpu_req = 1'b1; end
            3: begin dmaen = 1'b1; blten = 1'b1; blt_req = 1'b1; cpu_req = 1'b1; end
            4: begin dmaen = 1'b1; blten = 1'b1; blt_req = 1'b1; cpu_req = 1'b1; bltpri = 1'b1; end
            5: begin dmaen = 1'b1; copen = 1'b1; cop_req = 1'b1; blten = 1'b1; blt_req = 1'b1; end
            6: begin dmaen = 1'b1; dsken = 1'b1; spren = 1'b1; auden = 4'b0101; bpl_req = 1'b1; end
            7: cpu_req = 1'b1;
            default: ;
        endcase
        RST = 1'b1;
        ack_last = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // The CPU drops its request for one CLK after each expected ACK.
    task automatic run_window(input int id, input int cycles, input bit drop);
        int eg;
        for (int c = 0; c < cycles; c++) begin
            eg = exp_gnt(id, hp_m);
            checkOutput("hpos", 32'(hpos), 32'(hp_m));
            checkOutput("slot_ph", 32'(slot_ph), 32'(ph_m));
            checkOutput("gnt_id", 32'(gnt_id), 32'(eg));
            checkOutput("cpu_ack", 32'(cpu_ack), 32'(ph_m == 1 && eg == 8));
            checkOutput("dbr_n", 32'(dbr_n), 32'(!(cpu_req && eg != 8)));
            checkOutput("hstrobe", 32'(hstrobe), 32'(ph_m == 1 && hp_m == last_m()));
            checkOutput("lol", 32'(lol), 32'(lol_m));
            if (drop) begin
                cpu_req = ack_last ? 1'b0 : 1'b1;
                ack_last = (ph_m == 1 && eg == 8);
            end
            tick();
        end
    endtask

    task automatic measure_strobes();
        int n;
        int lol_before;
        int exp_int;
        n = 0;
        while (hstrobe !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("strobe_seen", 32'(hstrobe), 32'd1);
        for (int k = 0; k < 2; k++) begin
            lol_before = lol_m;
            tick();
            exp_int = (lol_m != 0) ? 2 * (LINE + 1) : 2 * LINE;
            n = 1;
            while (hstrobe !== 1'b1 && n < 1000) begin
                tick();
                n++;
            end
            checkOutput("strobe_interval", 32'(n), 32'(exp_int));
`ifdef ARB_NTSC_LONGLINE_EN
            checkOutput("lol_toggle", 32'(lol), 32'(1 - lol_before));
`else
            checkOutput("lol_tied", 32'(lol), 32'(lol_before));
`endif
        end
    endtask

    initial begin
        RST = 1'b1;
        @(negedge CLK);

        applyStimulus(1);
        run_window(1, 3 * 2 * (LINE + 1), 1'b0);
        measure_strobes();

        applyStimulus(2);
        run_window(2, 60, 1'b1);

        applyStimulus(7);
        run_window(7, 24, 1'b0);

        applyStimulus(3);
        run_window(3, 2 * 64, 1'b1);
        checkOutput("pre_reset_gnt", 32'(gnt_id), 32'd8);
        RST = 1'b1;
        tick();
        checkOutput("midreset_hpos", 32'(hpos), 32'd0);
        checkOutput("midreset_ph", 32'(slot_ph), 32'd0);
        checkOutput("midreset_gnt", 32'(gnt_id), 32'd0);
        checkOutput("midreset_ack", 32'(cpu_ack), 32'd0);
        RST = 1'b0;
        ack_last = 1'b0;
        cpu_req = 1'b1;
        run_window(3, 40, 1'b1);

        applyStimulus(4);
        run_window(4, 60, 1'b0);

        applyStimulus(5);
        run_window(5, 60, 1'b0);

        applyStimulus(6);
        run_window(6, 2 * 60, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
